gshare_predictor: RTL and testbench

//  Branch direction predictor for the front end; the counterpart of the branch execute unit.
//  - Fetch asks for a taken/not-taken prediction per conditional branch.
//  - Resolved outcomes (br_en, prediction, mispredict) return from commit and train
//    2-bit saturating counters.
//  - A speculative global history register (GHR) is restored from the resolving

---
 rtl/gshare_predictor.sv | 107 ++++++++++
 tb/tb_gshare_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: PC xor global history indexes a table of
// 2-bit saturating counters; speculative history is repaired on mispredict.
module gshare_predictor #(
   parameter int GHR_W     = 8,
   parameter int BHT_IDX_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pred_req,
   input  logic                 pred_is_br,
   input  logic [31:0]          pred_pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [GHR_W-1:0]     pred_ghr,
   input  logic                 upd_valid,
   input  logic                 upd_is_br,
   input  logic [31:0]          upd_pc,
   input  logic [GHR_W-1:0]     upd_ghr,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic [31:0]          perf_br_cnt,
   output logic [31:0]          perf_mp_cnt
);

   localparam int ENTRIES = 1 << BHT_IDX_W;

   logic [1:0]           pht [ENTRIES];
   logic [GHR_W-1:0]     ghr;
   logic [GHR_W-1:0]     ghr_next;
   logic [BHT_IDX_W-1:0] pred_idx;
   logic [BHT_IDX_W-1:0] upd_idx;
   logic                 pred_bit;
   logic                 recover;
   logic                 spec_shift;
   logic                 train;
   logic [1:0]           upd_ctr;
   logic [1:0]           ctr_next;
   logic                 unused;

   assign pred_idx   = pred_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
   assign upd_idx    = upd_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(upd_ghr);
   assign pred_bit   = pred_is_br & pht[pred_idx][1];
   assign recover    = upd_valid & upd_mispredict;
   assign spec_shift = pred_req & pred_is_br & ~recover;
   assign train      = upd_valid & upd_is_br;
   assign upd_ctr    = pht[upd_idx];
   assign unused     = ^{pred_pc[31:BHT_IDX_W+2], pred_pc[1:0],
                         upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

   always_comb begin
      ctr_next = upd_ctr;
      if (upd_taken) begin
         if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'd1;
      end else begin
         if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'd1;
      end
   end

   // Recovery from the resolving branch's snapshot outranks a speculative shift.
   always_comb begin
      ghr_next = ghr;
      if (recover) begin
         if (upd_is_br) ghr_next = {upd_ghr[GHR_W-2:0], upd_taken};
         else           ghr_next = upd_ghr;
      end else if (spec_shift) begin
         ghr_next = {ghr[GHR_W-2:0], pred_bit};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
      end else if (train) begin
         pht[upd_idx] <= ctr_next;
      end
   end

   // pred_valid pulses for exactly one cycle after each pred_req; there is no
   // ready/back-pressure, so fetch must take pred_taken/pred_ghr on that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr        <= '0;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_ghr   <= '0;
      end else begin
         ghr        <= ghr_next;
         pred_valid <= pred_req;
         if (pred_req) begin
            pred_taken <= pred_bit;
            pred_ghr   <= ghr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_br_cnt <= '0;
         perf_mp_cnt <= '0;
      end else if (train) begin
         if (perf_br_cnt != 32'hFFFF_FFFF) perf_br_cnt <= perf_br_cnt + 32'd1;
         if (upd_mispredict && perf_mp_cnt != 32'hFFFF_FFFF)
            perf_mp_cnt <= perf_mp_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios plus random traffic against a
// counter-table model built from plain integer arithmetic.
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_req, pred_is_br;
   logic [31:0] pred_pc;
   logic        pred_valid, pred_taken;
   logic [7:0]  pred_ghr;
   logic        upd_valid, upd_is_br, upd_taken, upd_mispredict;
   logic [31:0] upd_pc;
   logic [7:0]  upd_ghr;
   logic [31:0] perf_br_cnt, perf_mp_cnt;

   int total = 0;
   int bad   = 0;

   // reference state
   int m_pht [256];
   int m_ghr;
   int m_br, m_mp;
   int saved_br;

   always #5 clk = ~clk;

   gshare_predictor #(.GHR_W(8), .BHT_IDX_W(8)) dut (
      .clk(clk), .rst(rst),
      .pred_req(pred_req), .pred_is_br(pred_is_br), .pred_pc(pred_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
      .upd_valid(upd_valid), .upd_is_br(upd_is_br), .upd_pc(upd_pc),
      .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
      .perf_br_cnt(perf_br_cnt), .perf_mp_cnt(perf_mp_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int midx(input logic [31:0] pc, input int g);
      return ((pc >> 2) % 256) ^ g;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_ghr = 0;
      m_br  = 0;
      m_mp  = 0;
   endtask

   task automatic idle();
      pred_req = 0; pred_is_br = 0; pred_pc = 32'h0;
      upd_valid = 0; upd_is_br = 0; upd_pc = 32'h0; upd_ghr = 8'h0;
      upd_taken = 0; upd_mispredict = 0;
   endtask

   // One clock: advance the model from the present inputs, then check outputs.
   task automatic tick();
      int  pidx, ui, snap;
      bit  pbit, req;
      pidx = midx(pred_pc, m_ghr);
      pbit = pred_is_br && (m_pht[pidx] >= 2);
      snap = m_ghr;
      req  = pred_req;
      if (upd_valid && upd_is_br) begin
         ui = midx(upd_pc, int'(upd_ghr));
         if (upd_taken) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
         else           m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
         m_br++;
         if (upd_mispredict) m_mp++;
      end
      if (upd_valid && upd_mispredict)
         m_ghr = upd_is_br ? ((int'(upd_ghr) * 2 + int'(upd_taken)) % 256) : int'(upd_ghr);
      else if (pred_req && pred_is_br)
         m_ghr = (m_ghr * 2 + int'(pbit)) % 256;
      @(posedge clk);
      #1;
      chk("pred_valid", {31'b0, pred_valid}, {31'b0, req});
      if (req) begin
         chk("pred_taken", {31'b0, pred_taken}, {31'b0, pbit});
         chk("pred_ghr", {24'b0, pred_ghr}, snap);
      end
      chk("perf_br_cnt", perf_br_cnt, m_br);
      chk("perf_mp_cnt", perf_mp_cnt, m_mp);
   endtask

   task automatic set_ghr(input logic [7:0] v);
      idle();
      upd_valid = 1; upd_is_br = 0; upd_mispredict = 1; upd_ghr = v;
      tick();
      idle();
   endtask

   task automatic predict(input logic [31:0] pc);
      idle();
      pred_req = 1; pred_is_br = 1; pred_pc = pc;
      tick();
      idle();
   endtask

   task automatic train(input logic [31:0] pc, input logic [7:0] g, input logic t);
      idle();
      upd_valid = 1; upd_is_br = 1; upd_pc = pc; upd_ghr = g; upd_taken = t;
      tick();
      idle();
   endtask

   initial begin
      // reset
      idle();
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, pred_valid}, 0);
      chk("rst_taken", {31'b0, pred_taken}, 0);
      chk("rst_ghr", {24'b0, pred_ghr}, 0);
      chk("rst_br", perf_br_cnt, 0);
      chk("rst_mp", perf_mp_cnt, 0);
      rst = 0;
      tick();

      // first prediction: weakly not-taken, history zero
      predict(32'h6000_0010);
      chk("first_valid", {31'b0, pred_valid}, 1);
      chk("first_taken", {31'b0, pred_taken}, 0);
      chk("first_ghr", {24'b0, pred_ghr}, 8'h00);
      tick();
      chk("valid_drops", {31'b0, pred_valid}, 0);

      // train 01->10->11, then saturation
      train(32'h6000_0010, 8'h00, 1);
      train(32'h6000_0010, 8'h00, 1);
      predict(32'h6000_0010);
      chk("trained_taken", {31'b0, pred_taken}, 1);
      train(32'h6000_0010, 8'h00, 1);
      train(32'h6000_0010, 8'h00, 0);
      set_ghr(8'h00);
      predict(32'h6000_0010);
      chk("sat_taken", {31'b0, pred_taken}, 1);

      // three predicted-taken branches all landing on the trained entry
      set_ghr(8'h00);
      predict(32'h6000_0010);
      chk("tk1", {31'b0, pred_taken}, 1);
      predict(32'h6000_0014);
      chk("tk2", {31'b0, pred_taken}, 1);
      predict(32'h6000_001C);
      chk("tk3", {31'b0, pred_taken}, 1);

      // mispredict recovery with a same-cycle prediction
      pred_req = 1; pred_is_br = 1; pred_pc = 32'h6000_0020;
      upd_valid = 1; upd_is_br = 1; upd_pc = 32'h6000_0100; upd_ghr = 8'h01;
      upd_taken = 0; upd_mispredict = 1;
      tick();
      idle();
      chk("rec_valid", {31'b0, pred_valid}, 1);
      chk("rec_snap", {24'b0, pred_ghr}, 8'h07);
      predict(32'h6000_0030);
      chk("rec_ghr", {24'b0, pred_ghr}, 8'h02);

      // jal mispredict: history replaced, no branch counted
      saved_br = m_br;
      set_ghr(8'h55);
      chk("jal_br_cnt", perf_br_cnt, saved_br);
      predict(32'h6000_0040);
      chk("jal_ghr", {24'b0, pred_ghr}, 8'h55);

      // same-index predict and update: prediction sees the old counter
      set_ghr(8'h00);
      pred_req = 1; pred_is_br = 1; pred_pc = 32'h6000_0200;
      upd_valid = 1; upd_is_br = 1; upd_pc = 32'h6000_0200; upd_ghr = 8'h00;
      upd_taken = 1;
      tick();
      idle();
      chk("same_old", {31'b0, pred_taken}, 0);
      predict(32'h6000_0200);
      chk("same_new", {31'b0, pred_taken}, 1);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         pred_req       = ($urandom_range(0, 3) != 0);
         pred_is_br     = ($urandom_range(0, 4) != 0);
         pred_pc        = 32'h6000_0000 + ($urandom_range(0, 15) << 2);
         upd_valid      = ($urandom_range(0, 2) != 0);
         upd_is_br      = ($urandom_range(0, 5) != 0);
         upd_pc         = 32'h6000_0000 + ($urandom_range(0, 15) << 2);
         upd_ghr        = 8'($urandom_range(0, 7));
         upd_taken      = 1'($urandom_range(0, 1));
         upd_mispredict = ($urandom_range(0, 5) == 0);
         tick();
      end
      idle();

      // asynchronous reset between edges
      predict(32'h6000_0010);
      rst = 1;
      #2;
      chk("arst_valid", {31'b0, pred_valid}, 0);
      chk("arst_taken", {31'b0, pred_taken}, 0);
      chk("arst_ghr", {24'b0, pred_ghr}, 0);
      chk("arst_br", perf_br_cnt, 0);
      chk("arst_mp", perf_mp_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      predict(32'h6000_0010);
      chk("arst_pht", {31'b0, pred_taken}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
